// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: free-running h/v counters, sync decode and
// a one-stage registered output path fed by a valid/ready pixel stream.
module vga_timing_gen #(
    parameter int   COLOR_WIDTH = 4,
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [3*COLOR_WIDTH-1:0]   pix_data,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic                       HSync,
    output logic                       VSync,
    output logic [COLOR_WIDTH-1:0]     Red,
    output logic [COLOR_WIDTH-1:0]     Green,
    output logic [COLOR_WIDTH-1:0]     Blue,
    output logic                       active,
    output logic                       frame_start,
    output logic                       line_start,
    output logic                       underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW3     = 3 * COLOR_WIDTH;

    // Region boundaries; back porch >= 1 keeps every bound below TOTAL.
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0]  h_q, h_d;
    logic [VW-1:0]  v_q, v_d;
    logic           hsync_q, vsync_q, active_q, fs_q, ls_q, uf_q;
    logic [CW3-1:0] rgb_q;

    logic h_vis, v_vis, h_in_sync, v_in_sync;

    assign h_vis     = (h_q < H_ACT_L);
    assign v_vis     = (v_q < V_ACT_L);
    assign h_in_sync = (h_q >= H_SYNC_S) && (h_q < H_SYNC_E);
    assign v_in_sync = (v_q >= V_SYNC_S) && (v_q < V_SYNC_E);

    assign pix_ready = en & ~rst & h_vis & v_vis;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!en) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            active_q <= 1'b0;
            fs_q     <= 1'b0;
            ls_q     <= 1'b0;
            uf_q     <= 1'b0;
            rgb_q    <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= h_in_sync ? HS_POL : ~HS_POL;
            vsync_q  <= v_in_sync ? VS_POL : ~VS_POL;
            active_q <= pix_ready;
            fs_q     <= (h_q == '0) && (v_q == '0);
            ls_q     <= (h_q == '0);
            // A starved visible slot shows black and is flagged; nothing is consumed.
            uf_q     <= pix_ready & ~pix_valid;
            rgb_q    <= (pix_ready && pix_valid) ? pix_data : '0;
        end
    end

    assign HSync       = hsync_q;
    assign VSync       = vsync_q;
    assign active      = active_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign underflow   = uf_q;
    assign Red         = rgb_q[CW3-1:2*COLOR_WIDTH];
    assign Green       = rgb_q[2*COLOR_WIDTH-1:COLOR_WIDTH];
    assign Blue        = rgb_q[COLOR_WIDTH-1:0];

endmodule
